// File: rtl/write_b_in_pkg.sv
// Shared definitions for the write_b_in buffer writer: bank-state encoding,
// default parameter values and capacity helpers.
package write_b_in_pkg;

   typedef enum logic {
      W0 = 1'b0,
      W1 = 1'b1
   } bank_state_e;

   localparam int unsigned DEF_FREESPACE_UPDATE_SIZE = 64;
   localparam int unsigned DEF_PAYLOAD_BITS          = 64;
   localparam int unsigned DEF_NUM_ADDR_BITS         = 7;

   localparam int unsigned DEF_CAPACITY = 2 ** DEF_NUM_ADDR_BITS;

   // Total words held across both banks for a given address width.
   function automatic int unsigned capacity(input int unsigned num_addr_bits);
      return 32'd1 << num_addr_bits;
   endfunction

endpackage

// File: rtl/b_in_credit_cnt.sv
// Occupancy tracking for write_b_in: counts accepted words, releases them in
// freespace_update chunks with clamp-to-zero, and derives ready from the count.
module b_in_credit_cnt
   import write_b_in_pkg::*;
#(
   parameter int unsigned FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE,
   parameter int unsigned NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     accept,
   input  logic                     freespace_update,
   output logic [NUM_ADDR_BITS:0]   occupancy,
   output logic                     rdy_bram2user,
   output logic                     underflow
);

   localparam int unsigned Capacity = capacity(NUM_ADDR_BITS);
   localparam int unsigned OccW     = NUM_ADDR_BITS + 1;

   logic [OccW-1:0] occ_q, occ_d;
   logic [31:0]     occ_plus_acc;

   // Accept is folded in before the release so a same-cycle pair nets out.
   always_comb begin
      occ_plus_acc = 32'(occ_q) + 32'(accept);
      underflow    = 1'b0;
      occ_d        = OccW'(occ_plus_acc);
      if (freespace_update) begin
         if (occ_plus_acc < FREESPACE_UPDATE_SIZE) begin
            underflow = 1'b1;
            occ_d     = '0;
         end else begin
            occ_d = OccW'(occ_plus_acc - FREESPACE_UPDATE_SIZE);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy     = occ_q;
   assign rdy_bram2user = (32'(occ_q) != Capacity);

   occ_bounded_a : assert property (@(posedge clk) disable iff (!reset)
      32'(occ_q) <= Capacity);

   no_accept_when_full_a : assert property (@(posedge clk) disable iff (!reset)
      !(accept && !rdy_bram2user));

endmodule

// File: rtl/write_b_in.sv
// Ping-pong BRAM writer: alternates accepted words between two banks with
// independent write addresses. Optional error flags under WRITE_B_IN_ERR_CHK_EN.
module write_b_in
   import write_b_in_pkg::*;
#(
   parameter int unsigned FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE,
   parameter int unsigned PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
   parameter int unsigned NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PAYLOAD_BITS-1:0]    din_leaf_user2bram,
   input  logic                       vld_user2bram,
   output logic                       rdy_bram2user,
   input  logic                       freespace_update,
   output logic [NUM_ADDR_BITS-2:0]   addra_0,
   output logic [NUM_ADDR_BITS-2:0]   addra_1,
   output logic [PAYLOAD_BITS:0]      dina,
   output logic                       wea_0,
   output logic                       wea_1,
   output logic [NUM_ADDR_BITS:0]     occupancy,
   output logic [1:0]                 err_flags
);

   localparam int unsigned BankAw = NUM_ADDR_BITS - 1;
   localparam logic [BankAw-1:0] AddrOne = BankAw'(1);

   bank_state_e       state_q;
   logic [BankAw-1:0] addr0_q, addr1_q;
   logic              accept;
   logic              underflow;

   // Gating with reset keeps both enables low for the whole reset window.
   assign accept = vld_user2bram && rdy_bram2user && reset;
   assign wea_0  = accept && (state_q == W0);
   assign wea_1  = accept && (state_q == W1);
   assign dina   = {1'b1, din_leaf_user2bram};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= W0;
         addr0_q <= '0;
         addr1_q <= '0;
      end else if (accept) begin
         unique case (state_q)
            W0: begin
               addr0_q <= addr0_q + AddrOne;
               state_q <= W1;
            end
            W1: begin
               addr1_q <= addr1_q + AddrOne;
               state_q <= W0;
            end
            default: state_q <= W0;
         endcase
      end
   end

   assign addra_0 = addr0_q;
   assign addra_1 = addr1_q;

   b_in_credit_cnt #(
      .FREESPACE_UPDATE_SIZE (FREESPACE_UPDATE_SIZE),
      .NUM_ADDR_BITS         (NUM_ADDR_BITS)
   ) u_credit_cnt (
      .clk              (clk),
      .reset            (reset),
      .accept           (accept),
      .freespace_update (freespace_update),
      .occupancy        (occupancy),
      .rdy_bram2user    (rdy_bram2user),
      .underflow        (underflow)
   );

`ifdef WRITE_B_IN_ERR_CHK_EN
   logic [1:0] err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 2'b00;
      end else begin
         if (vld_user2bram && !rdy_bram2user) err_q[0] <= 1'b1;
         if (underflow)                       err_q[1] <= 1'b1;
      end
   end

   assign err_flags = err_q;
`else
   logic unused_underflow;
   assign unused_underflow = underflow;
   assign err_flags        = 2'b00;
`endif

   one_bank_write_a : assert property (@(posedge clk) disable iff (!reset)
      !(wea_0 && wea_1));

endmodule

// File: tb/tb_write_b_in.sv
// Scoreboard bench for write_b_in: a word-count model predicts bank/address,
// occupancy, ready and error flags; a negedge monitor compares each cycle.
module tb_write_b_in;

   localparam int PB  = 64;
   localparam int AW  = 7;
   localparam int FSU = 64;
   localparam int CAP = 128;
   localparam int BANK_DEPTH = 64;

   logic            clk;
   logic            reset;
   logic [PB-1:0]   din;
   logic            vld;
   logic            rdy;
   logic            upd;
   logic [AW-2:0]   addra_0, addra_1;
   logic [PB:0]     dina;
   logic            wea_0, wea_1;
   logic [AW:0]     occupancy;
   logic [1:0]      err_flags;

   write_b_in #(
      .FREESPACE_UPDATE_SIZE (FSU),
      .PAYLOAD_BITS          (PB),
      .NUM_ADDR_BITS         (AW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .din_leaf_user2bram (din),
      .vld_user2bram      (vld),
      .rdy_bram2user      (rdy),
      .freespace_update   (upd),
      .addra_0            (addra_0),
      .addra_1            (addra_1),
      .dina               (dina),
      .wea_0              (wea_0),
      .wea_1              (wea_1),
      .occupancy          (occupancy),
      .err_flags          (err_flags)
   );

   typedef struct {
      bit          rdy;
      int          occ;
      bit          acc;
      int          bank;
      int          addr;
      logic [PB:0] data;
      logic [1:0]  err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 0;

   // Reference model: words written since reset, live word count, sticky errors.
   int         m_occ = 0;
   int         m_k   = 0;
   logic [1:0] m_err = 2'b00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One stimulus cycle: drive inputs, record what the DUT must show, advance model.
   task automatic cycle(input bit v, input bit u, input logic [PB-1:0] d);
      exp_t e;
      int   tmp;
      @(posedge clk);
      #1;
      vld = v;
      upd = u;
      din = d;
      e.rdy  = (m_occ != CAP);
      e.occ  = m_occ;
      e.acc  = v && e.rdy;
      e.bank = m_k % 2;
      e.addr = (m_k / 2) % BANK_DEPTH;
      e.data = {1'b1, d};
      e.err  = m_err;
`ifdef WRITE_B_IN_ERR_CHK_EN
      if (v && !e.rdy) m_err[0] = 1'b1;
`endif
      if (e.acc) m_k++;
      tmp = m_occ + (e.acc ? 1 : 0);
      if (u) begin
         if (tmp < FSU) begin
            m_occ = 0;
`ifdef WRITE_B_IN_ERR_CHK_EN
            m_err[1] = 1'b1;
`endif
         end else begin
            m_occ = tmp - FSU;
         end
      end else begin
         m_occ = tmp;
      end
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en && sb.size() > 0) begin
         e = sb.pop_front();
         chk("rdy", 128'(rdy), 128'(e.rdy));
         chk("occupancy", 128'(occupancy), 128'(e.occ));
         chk("wea_0", 128'(wea_0), 128'(e.acc && e.bank == 0));
         chk("wea_1", 128'(wea_1), 128'(e.acc && e.bank == 1));
         chk("err_flags", 128'(err_flags), 128'(e.err));
         if (e.acc) begin
            if (e.bank == 0) chk("addra_0", 128'(addra_0), 128'(e.addr));
            else             chk("addra_1", 128'(addra_1), 128'(e.addr));
            chk("dina", 128'(dina), 128'(e.data));
         end
      end
   end

   // Drops reset with vld at the given level; everything must read idle meanwhile.
   task automatic do_reset(input bit v);
      @(negedge clk);
      #1;
      chk("sb_drained", 128'(sb.size()), 128'(0));
      mon_en = 1'b0;
      vld    = v;
      upd    = 1'b0;
      din    = {$urandom, $urandom};
      reset  = 1'b0;
      #1;
      chk("rst_wea_0", 128'(wea_0), 128'(0));
      chk("rst_wea_1", 128'(wea_1), 128'(0));
      chk("rst_addra_0", 128'(addra_0), 128'(0));
      chk("rst_addra_1", 128'(addra_1), 128'(0));
      chk("rst_occupancy", 128'(occupancy), 128'(0));
      chk("rst_err_flags", 128'(err_flags), 128'(0));
      @(posedge clk);
      #1;
      chk("rst_hold_wea", 128'({wea_0, wea_1}), 128'(0));
      @(negedge clk);
      #1;
      vld    = 1'b0;
      reset  = 1'b1;
      m_occ  = 0;
      m_k    = 0;
      m_err  = 2'b00;
      mon_en = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      vld   = 1'b0;
      upd   = 1'b0;
      din   = '0;

      // Four words alternate banks, bank 0 first.
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, PB'(64'hA + i));
      cycle(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      chk("occ_after_4", 128'(occupancy), 128'(4));

      // Fill to capacity, stall, then release one chunk and resume at bank 0 addr 0.
      do_reset(1'b0);
      for (int i = 0; i < 140; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
      cycle(1'b1, 1'b1, {$urandom, $urandom});
      cycle(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      chk("occ_after_release", 128'(occupancy), 128'(64));
      chk("rdy_after_release", 128'(rdy), 128'(1));
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});

      // Accept and release in the same cycle at 70.
      do_reset(1'b0);
      for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
      cycle(1'b1, 1'b1, {$urandom, $urandom});
      cycle(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      chk("occ_70_acc_upd", 128'(occupancy), 128'(7));

      // Release larger than the live count clamps to zero.
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
      cycle(1'b0, 1'b1, '0);
      cycle(1'b0, 1'b0, '0);

      // Reset mid-burst with the writer sitting in bank 1.
      do_reset(1'b0);
      for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});

      // Random traffic with occasional releases.
      do_reset(1'b0);
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, {$urandom, $urandom});
      end
      cycle(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      chk("sb_final_drained", 128'(sb.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
